// File: rtl/sll_seq_pkg.sv
// Shared definitions for the sequential shift-left unit: state encodings
// and default operand/shift-amount widths.
package sll_seq_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/sll_seq_sll_1.sv
// One-position left shifter built from 2:1 mux cells. The fill bit is an
// input, so rotate versus zero-fill is purely a wiring choice in the parent.
// When i_en is low the operand passes through unchanged.

// Single-bit 2:1 multiplexer cell
module mux2_1 (
  input  logic i_a,
  input  logic i_b,
  input  logic i_sel,
  output logic o_y
);
  // select i_b when i_sel is high, else i_a
  always_comb begin
    o_y = i_sel ? i_b : i_a;
  end
endmodule

module sll_1 #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_d,
  input  logic             i_fill,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_q
);

  // Shifted-in source for each bit position: bit 0 takes the fill bit
  logic [WIDTH-1:0] w_src;

  assign w_src[0] = i_fill;

  genvar gi;
  generate
    for (gi = 1; gi < WIDTH; gi++) begin : g_src
      assign w_src[gi] = i_d[gi-1];
    end
    for (gi = 0; gi < WIDTH; gi++) begin : g_mux
      mux2_1 u_mux (
        .i_a   (i_d[gi]),
        .i_b   (w_src[gi]),
        .i_sel (i_en),
        .o_y   (o_q[gi])
      );
    end
  endgenerate

endmodule

// File: rtl/sll_seq.sv
// Multi-cycle shift-left unit: one bit position per clock with a
// start/busy/done handshake. Defining SLL_SEQ_ROTATE_EN turns the zero fill
// into a rotate-left (bit 0 takes the old MSB); timing is identical.
module sll_seq
  import sll_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] In,
  input  logic [CNT_W-1:0] Cnt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Out
);

  state_t           r_state;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_out;
  logic             r_busy;
  logic             r_done;

  logic             w_fill;
  logic             w_shift_en;
  logic [WIDTH-1:0] w_shifted;

`ifdef SLL_SEQ_ROTATE_EN
  assign w_fill = r_out[WIDTH-1];
`else
  assign w_fill = 1'b0;
`endif

  assign w_shift_en = (r_state == ST_SHIFT);

  sll_1 #(
    .WIDTH (WIDTH)
  ) u_sll_1 (
    .i_d    (r_out),
    .i_fill (w_fill),
    .i_en   (w_shift_en),
    .o_q    (w_shifted)
  );

  // State, count, result and registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_out   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_out   <= In;
            r_count <= Cnt;
            if (Cnt != '0) begin
              // zero-length shifts skip SHIFT and finish next cycle
              r_state <= ST_SHIFT;
              r_busy  <= 1'b1;
            end else begin
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end else begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        ST_SHIFT: begin
          r_out   <= w_shifted;
          r_count <= r_count - CNT_W'(1);
          if (r_count == CNT_W'(1)) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_state <= ST_SHIFT;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
          end
        end
        default: begin
          // unreachable encoding: recover quietly to IDLE
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign Out  = r_out;

endmodule

// File: tb/tb_sll_seq.sv
// Directed self-checking bench for sll_seq (honours SLL_SEQ_ROTATE_EN for
// the expected results that differ in rotate mode).
`timescale 1ns/1ps
module tb_sll_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] In;
  logic [3:0]  Cnt;
  logic        busy;
  logic        done;
  logic [15:0] Out;

  int checks   = 0;
  int failures = 0;

  sll_seq #(
    .WIDTH (16),
    .CNT_W (4)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .In    (In),
    .Cnt   (Cnt),
    .busy  (busy),
    .done  (done),
    .Out   (Out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one cycle; outputs are sampled 1ns after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %s observed=%h expected=%h", tag, obs, exp);
  endtask

  initial begin
    int n;
    int seen;
    logic [15:0] exp3;
    logic [15:0] exp4;
`ifdef SLL_SEQ_ROTATE_EN
    exp3 = 16'hFFFF;
    exp4 = 16'h0003;
`else
    exp3 = 16'h8000;
    exp4 = 16'h0002;
`endif

    // reset
    rst = 1'b1; start = 1'b0; In = '0; Cnt = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_out",  32'(Out),  32'd0);

    // test 1: 0x0001 << 4
    In = 16'h0001; Cnt = 4'd4; start = 1'b1;
    tick(); start = 1'b0;
    chk("t1_load_out", 32'(Out), 32'h0001);
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("t1_busy_c%0d", i), 32'(busy), 32'd1);
      chk($sformatf("t1_nodone_c%0d", i), 32'(done), 32'd0);
      tick();
    end
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_busy_off", 32'(busy), 32'd0);
    chk("t1_out", 32'(Out), 32'h0010);
    tick();
    chk("t1_done_pulse", 32'(done), 32'd0);
    chk("t1_out_hold", 32'(Out), 32'h0010);

    // test 2: Cnt=0
    In = 16'hA5A5; Cnt = 4'd0; start = 1'b1;
    tick(); start = 1'b0;
    chk("t2_done", 32'(done), 32'd1);
    chk("t2_busy", 32'(busy), 32'd0);
    chk("t2_out", 32'(Out), 32'hA5A5);
    tick();
    chk("t2_done_off", 32'(done), 32'd0);
    chk("t2_busy_off", 32'(busy), 32'd0);

    // test 3: 0xFFFF << 15, done expected at cycle 16
    In = 16'hFFFF; Cnt = 4'd15; start = 1'b1;
    tick(); start = 1'b0;
    n = 1;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    chk("t3_latency", 32'(n), 32'd16);
    chk("t3_out", 32'(Out), 32'(exp3));
    tick();

    // test 4: Cnt=1 then back-to-back start in the DONE cycle
    In = 16'h8001; Cnt = 4'd1; start = 1'b1;
    tick(); start = 1'b0;
    chk("t4_busy_c1", 32'(busy), 32'd1);
    tick();
    chk("t4_done_a", 32'(done), 32'd1);
    chk("t4_out_a", 32'(Out), 32'(exp4));
    In = 16'h0003; Cnt = 4'd2; start = 1'b1;
    tick(); start = 1'b0;
    chk("t4_b2b_busy", 32'(busy), 32'd1);
    chk("t4_b2b_nodone", 32'(done), 32'd0);
    tick();
    chk("t4_b2b_busy2", 32'(busy), 32'd1);
    tick();
    chk("t4_done_b", 32'(done), 32'd1);
    chk("t4_out_b", 32'(Out), 32'h000C);
    tick();

    // test 5: start while busy is ignored
    In = 16'h1234; Cnt = 4'd3; start = 1'b1;
    tick(); start = 1'b0;
    tick();
    In = 16'hFFFF; Cnt = 4'd0; start = 1'b1;
    tick(); start = 1'b0;
    chk("t5_busy_c3", 32'(busy), 32'd1);
    chk("t5_nodone_c3", 32'(done), 32'd0);
    tick();
    chk("t5_done", 32'(done), 32'd1);
    chk("t5_out", 32'(Out), 32'h91A0);
    tick();
    chk("t5_idle_done", 32'(done), 32'd0);

    // test 6: reset mid-operation
    In = 16'h00FF; Cnt = 4'd8; start = 1'b1;
    tick(); start = 1'b0;
    tick();
    tick();
    chk("t6_busy_c3", 32'(busy), 32'd1);
    rst = 1'b1;
    tick(); rst = 1'b0;
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_done", 32'(done), 32'd0);
    chk("t6_out", 32'(Out), 32'd0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) seen++;
      tick();
    end
    chk("t6_no_done", 32'(seen), 32'd0);
    chk("t6_out_hold", 32'(Out), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
